// File: rtl/mem_arbiter.sv
// Shares the single-port memory between fetch and load/store: 0-cycle grant, 1-cycle routed response.
// Load/store has priority; fetch overrides it after STARVE_MAX denied cycles; flush kills fetch grants and responses.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  input  logic [3:0]    ls_wstrb,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [31:0]   ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          pend_q, pend_d;
  logic          own_q, own_d;
  logic          if_ok;
  logic          gnt_if, gnt_ls;

  // Grants are suppressed during reset so nothing reaches the memory or the state.
  always_comb begin
    if_ok  = if_req & ~if_flush;
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (!rst) begin
      if (if_ok && starve_q == STARVE_LIM) gnt_if = 1'b1;
      else if (ls_req)                     gnt_ls = 1'b1;
      else if (if_ok)                      gnt_if = 1'b1;
    end
  end

  always_comb begin
    mem_en    = gnt_if | gnt_ls;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt_ls) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_wstrb = ls_we ? ls_wstrb : 4'b0000;
    end else if (gnt_if) begin
      mem_addr = if_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_if || !if_req || if_flush) starve_d = '0;
    else if (starve_q != STARVE_LIM)   starve_d = starve_q + CW'(1);
    pend_d = gnt_if | gnt_ls;
    own_d  = gnt_ls;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      pend_q   <= 1'b0;
      own_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
      own_q    <= own_d;
    end
  end

  assign if_gnt    = gnt_if;
  assign ls_gnt    = gnt_ls;
  // A fetch response due in a flush cycle belongs to a dead instruction stream.
  assign if_rvalid = pend_q & ~own_q & ~if_flush & ~rst;
  assign ls_rvalid = pend_q & own_q & ~rst;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for reset/starvation, random run against a model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int SM = 4;

  logic          clk, rst;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata, ls_rdata;
  logic [3:0]    ls_wstrb;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  mem_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-owned memory: read-before-write, data valid the cycle after mem_en.
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr[9:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      mem_rdata <= 32'h0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic fl, input logic [31:0] ia,
                       input logic lr, input logic we, input logic [31:0] la,
                       input logic [31:0] wd, input logic [3:0] ws);
    if_req = ir; if_flush = fl; if_addr = ia;
    ls_req = lr; ls_we = we; ls_addr = la; ls_wdata = wd; ls_wstrb = ws;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        ir, fl, lr, we;
    logic [31:0] ia, la, wd;
    logic [3:0]  ws;
    logic        e_ig, e_lg, e_we;
    logic [31:0] e_addr;
    logic        e_irv, e_lrv, e_chk;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [10];

  // Model state for the random phase.
  int          m_starve;
  bit          m_pend, m_own, m_chk;
  logic [31:0] m_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[4] = 32'h0010_0093;
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);

    // Reset held with both requests active: every output stays 0.
    for (int c = 0; c < 3; c++) begin
      #4;
      check("rst_if_gnt", if_gnt, 0);    check("rst_ls_gnt", ls_gnt, 0);
      check("rst_mem_en", mem_en, 0);    check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0); check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_if_rvalid", if_rvalid, 0); check("rst_ls_rvalid", ls_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);   check("rst_ls_rdata", ls_rdata, 0);
      next_cycle();
    end
    rst = 1'b0;
    #2;
    check("post_rst_ls_gnt", ls_gnt, 1);
    check("post_rst_if_gnt", if_gnt, 0);
    check("post_rst_if_rvalid", if_rvalid, 0);
    check("post_rst_ls_rvalid", ls_rvalid, 0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    check("post_rst_ls_resp", ls_rvalid, 1);
    check("post_rst_ls_data", ls_rdata, 32'hA500_0040);

    // Directed vectors: single fetch, store/load, alternation, flush.
    vt[0] = '{1'b1,1'b0,1'b0,1'b0, 32'h10,32'h0,32'h0,4'h0, 1'b1,1'b0,1'b0,32'h10,  1'b0,1'b0,1'b0,32'h0};
    vt[1] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,4'h0,  1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b1,32'h0010_0093};
    vt[2] = '{1'b0,1'b0,1'b1,1'b1, 32'h0,32'h100,32'hDEADBEEF,4'hF, 1'b0,1'b1,1'b1,32'h100, 1'b0,1'b0,1'b0,32'h0};
    vt[3] = '{1'b0,1'b0,1'b1,1'b0, 32'h0,32'h100,32'h0,4'h0, 1'b0,1'b1,1'b0,32'h100, 1'b0,1'b1,1'b0,32'h0};
    vt[4] = '{1'b1,1'b0,1'b0,1'b0, 32'h10,32'h0,32'h0,4'h0, 1'b1,1'b0,1'b0,32'h10,  1'b0,1'b1,1'b1,32'hDEADBEEF};
    vt[5] = '{1'b0,1'b0,1'b1,1'b0, 32'h0,32'h100,32'h0,4'h0, 1'b0,1'b1,1'b0,32'h100, 1'b1,1'b0,1'b1,32'h0010_0093};
    vt[6] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,4'h0,  1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,32'hDEADBEEF};
    vt[7] = '{1'b1,1'b0,1'b0,1'b0, 32'h20,32'h0,32'h0,4'h0, 1'b1,1'b0,1'b0,32'h20,  1'b0,1'b0,1'b0,32'h0};
    vt[8] = '{1'b1,1'b1,1'b1,1'b0, 32'h24,32'h20,32'h0,4'h0, 1'b0,1'b1,1'b0,32'h20, 1'b0,1'b0,1'b0,32'h0};
    vt[9] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,4'h0,  1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,32'hA500_0008};

    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(vt[i].ir, vt[i].fl, vt[i].ia, vt[i].lr, vt[i].we, vt[i].la, vt[i].wd, vt[i].ws);
      #2;
      check($sformatf("v%0d_if_gnt", i), if_gnt, vt[i].e_ig);
      check($sformatf("v%0d_ls_gnt", i), ls_gnt, vt[i].e_lg);
      check($sformatf("v%0d_mem_en", i), mem_en, vt[i].e_ig | vt[i].e_lg);
      check($sformatf("v%0d_mem_we", i), mem_we, vt[i].e_we);
      check($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
      check($sformatf("v%0d_mem_wstrb", i), mem_wstrb, vt[i].e_we ? vt[i].ws : 4'h0);
      if (vt[i].e_we || !vt[i].e_lg)
        check($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_we ? vt[i].wd : 32'h0);
      check($sformatf("v%0d_if_rvalid", i), if_rvalid, vt[i].e_irv);
      check($sformatf("v%0d_ls_rvalid", i), ls_rvalid, vt[i].e_lrv);
      check($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].e_irv ? vt[i].e_rd : 32'h0);
      if (vt[i].e_chk || !vt[i].e_lrv)
        check($sformatf("v%0d_ls_rdata", i), ls_rdata, vt[i].e_lrv ? vt[i].e_rd : 32'h0);
    end

    // Continuous contention: fetch wins every (SM+1)-th cycle.
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      #2;
      check($sformatf("starve%0d_if_gnt", i), if_gnt, (i % (SM + 1)) == SM);
      check($sformatf("starve%0d_ls_gnt", i), ls_gnt, (i % (SM + 1)) != SM);
    end

    // Reset right after a fetch grant: the response must not appear.
    next_cycle();
    rst = 1'b1;
    #2;
    check("midrst_if_rvalid", if_rvalid, 0);
    check("midrst_ls_gnt", ls_gnt, 0);
    next_cycle();
    #2;
    check("midrst2_mem_en", mem_en, 0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    check("midrst_exit_if_rvalid", if_rvalid, 0);
    check("midrst_exit_ls_rvalid", ls_rvalid, 0);

    // Random traffic against the model.
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    m_starve = 0; m_pend = 0; m_own = 0; m_chk = 0; m_data = 32'h0;
    for (int c = 0; c < 600; c++) begin
      bit          ok, exp_irv, exp_lrv;
      int          g;
      logic [31:0] a;
      next_cycle();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            {22'h0, 8'($urandom_range(0, 255)), 2'b00},
            $urandom_range(0, 9) < 7, 1'($urandom),
            {22'h0, 8'($urandom_range(0, 255)), 2'b00},
            $urandom, 4'($urandom));
      ok = if_req && !if_flush;
      if (ok && m_starve >= SM) g = 1;
      else if (ls_req)          g = 2;
      else if (ok)              g = 1;
      else                      g = 0;
      exp_irv = m_pend && !m_own && !if_flush;
      exp_lrv = m_pend && m_own;
      #2;
      check("rnd_if_gnt", if_gnt, g == 1);
      check("rnd_ls_gnt", ls_gnt, g == 2);
      check("rnd_mem_en", mem_en, g != 0);
      check("rnd_mem_we", mem_we, g == 2 && ls_we);
      check("rnd_mem_addr", mem_addr, g == 0 ? 32'h0 : (g == 1 ? if_addr : ls_addr));
      check("rnd_mem_wstrb", mem_wstrb, (g == 2 && ls_we) ? ls_wstrb : 4'h0);
      if (!(g == 2 && !ls_we))
        check("rnd_mem_wdata", mem_wdata, (g == 2) ? ls_wdata : 32'h0);
      check("rnd_if_rvalid", if_rvalid, exp_irv);
      check("rnd_ls_rvalid", ls_rvalid, exp_lrv);
      check("rnd_if_rdata", if_rdata, exp_irv ? m_data : 32'h0);
      if (!exp_lrv)    check("rnd_ls_rdata_idle", ls_rdata, 0);
      else if (m_chk)  check("rnd_ls_rdata", ls_rdata, m_data);

      m_pend = (g != 0);
      m_own  = (g == 2);
      m_chk  = !(g == 2 && ls_we);
      if (g != 0) begin
        a = (g == 1) ? if_addr : ls_addr;
        m_data = shadow[a[9:2]];
        if (g == 2 && ls_we)
          for (int b = 0; b < 4; b++)
            if (ls_wstrb[b]) shadow[a[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
      end
      if (if_req && !if_flush && g != 1) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else                               m_starve = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter that shares the single-port SoC memory between the CPU instruction-fetch port and the load/store port. It sits between the CPU and the memory. It grants at most one access per cycle, with fixed priority to load/store plus an anti-starvation override for fetch. It routes each 1-cycle-latency read response back to the master that issued the access, and drops in-flight fetch responses when the pipeline flushes on a jump.

## Interface
- AW, 32, address width of all ports
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch overrides load/store priority (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  AW  fetch address (word aligned)
- if_flush  in  1  pipeline flush (jump taken); kills fetch traffic this cycle
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch response data
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  load/store address
- ls_wdata  in  32  store data
- ls_wstrb  in  4  store byte enables
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid, or store acknowledge
- ls_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables, 0 on reads
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

## Operation
**Arbitration** is combinational, once per cycle:
- Let if_ok = if_req & ~if_flush.
- If starve_cnt == STARVE_MAX and if_ok: grant fetch.
- Else if ls_req: grant load/store.
- Else if if_ok: grant fetch.
- Else: no grant.

**Memory drive:**
- The granted master's fields drive mem_* in the grant cycle, and mem_en = 1.
- Fetch grants drive mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
- With no grant: mem_en = 0, and all other mem_* are 0.

**Starvation counter** (starve_cnt, clog2(STARVE_MAX+1) bits):
- Increments when if_req & ~if_gnt & ~if_flush, saturating at STARVE_MAX.
- Clears to 0 when if_gnt is high, if_req is low, or if_flush is high.

**Response tracking** is registered:
- pend_q is set when a grant occurs.
- own_q records the owner (0 = fetch, 1 = load/store).
- The cycle after a grant, the owner's rvalid is asserted and its rdata = mem_rdata.
- The non-owner's rvalid is 0 and its rdata holds 0.
- Store grants also produce ls_rvalid (acknowledge); ls_rdata is don't-care but driven from mem_rdata.

**Flush:**
- When if_flush is high, if_gnt is forced 0.
- When if_flush is high, if_rvalid is forced 0 in that same cycle, dropping any fetch response due.
- Load/store traffic is unaffected by flush.

## Timing
- Reset values: if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we = 0; all data/address outputs = 0; starve_cnt = 0; pend_q = 0.
- Reset mid-operation: a grant issued in the cycle rst is high does not update state. No rvalid appears in the first cycle after rst falls.
- Grant latency: 0 cycles (gnt in the same cycle as req, when the arbiter selects it).
- Response latency: exactly 1 cycle after the grant.
- Throughput: one access per cycle. Back-to-back grants to either or alternating masters are legal. A response and a new grant may share a cycle.
- Simultaneous if_req and ls_req with starve_cnt < STARVE_MAX: load/store wins and starve_cnt increments.
- Continuous ls_req with continuous if_req: fetch is granted on every (STARVE_MAX+1)-th cycle, i.e. once starve_cnt reaches STARVE_MAX.
- if_flush in the same cycle as a fetch rvalid: that response is dropped. A fetch granted in the cycle before is lost, and the fetch unit must reissue it.
- Masters must hold req and fields stable until gnt. The arbiter does not latch unaccepted requests.

## Test plan
- **Reset:** rst high for 3 cycles with if_req = ls_req = 1 → all outputs 0 throughout. First grant occurs on the first cycle with rst low; no rvalid on that cycle.
- **Single fetch:** if_req, if_addr = 0x10, memory word 0x00100093 → if_gnt and mem_en with mem_addr = 0x10 in cycle N. In cycle N+1, if_rvalid = 1, if_rdata = 0x00100093, ls_rvalid = 0.
- **Store then load:** ls_we = 1, ls_addr = 0x100, ls_wdata = 0xDEADBEEF, wstrb = 0xF, then a load of 0x100 → mem_we = 1 then 0 on consecutive cycles. ls_rvalid on both following cycles, and the second returns 0xDEADBEEF.
- **Contention / starvation:** if_req and ls_req held for 12 cycles with STARVE_MAX = 4 → grant pattern LS, LS, LS, LS, IF, repeating. starve_cnt never exceeds 4.
- **Flush:** fetch granted in cycle N, if_flush in N+1 → if_rvalid = 0 in N+1, and no if_gnt in N+1 even with if_req high. A concurrent ls grant is unaffected.
- **Back-to-back alternation:** fetch granted in N, load granted in N+1 → if_rvalid in N+1 and ls_rvalid in N+2, each carrying its own memory word.
